// File: rtl/megacart_nvram_xfer.sv
// megacart_nvram_xfer: streams the MegaCart 8K NVRAM image between host and SDRAM, mapping image offsets to CPU addresses
module megacart_nvram_xfer #(
  parameter bit         COMPACT   = 1'b0,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        abort,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        aborted,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        mem_req,
  output logic        mem_wr_n,
  output logic        mem_nvram_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_WR, SV_RD, SV_OUT, FINISH} state_t;
  localparam logic [12:0] LAST = COMPACT ? 13'd5119 : 13'd8191;
  state_t state, state_nx;
  logic [12:0] offs, offs_nx;
  logic [15:0] map_addr;
  logic [7:0] wdata_nx, odata_nx;
  logic abort_q, abort_q_nx, aborted_nx, mapped, last, stop;
  assign mapped = COMPACT || (offs >= 13'h0400 && offs < 13'h1000) || offs >= 13'h1800;
  // packed image: 3K block at 0x0400, then 2K block at 0x9800 (0x9800 - 3072 = 0x8C00)
  assign map_addr = !COMPACT ? {offs[12] ? 3'b100 : 3'b000, offs}
                  : offs < 13'd3072 ? {3'b000, offs} + 16'h0400 : {3'b000, offs} + 16'h8C00;
  assign last = offs == LAST;
  assign stop = abort | abort_q;
  assign busy = state inside {LD_WAIT, LD_WR, SV_RD, SV_OUT};
  assign cpu_hold = busy;
  assign done = state == FINISH;
  assign in_ready = state == LD_WAIT;
  assign out_valid = state == SV_OUT;
  assign mem_req = state == LD_WR || (state == SV_RD && mapped);
  assign mem_wr_n = state != LD_WR;
  assign mem_nvram_sel = mem_req;
  assign mem_addr = mem_req ? map_addr : '0;
  always_comb begin
    state_nx = state;
    offs_nx = offs;
    abort_q_nx = abort_q | (abort & mem_req);
    aborted_nx = 1'b0;
    wdata_nx = mem_wdata;
    odata_nx = out_data;
    case (state)
      IDLE: begin
        abort_q_nx = 1'b0;
        offs_nx = '0;
        state_nx = load_req ? LD_WAIT : save_req ? SV_RD : IDLE;
      end
      LD_WAIT: begin
        if (abort) begin
          state_nx = IDLE;
          aborted_nx = 1'b1;
        end else if (in_valid && mapped) begin
          wdata_nx = in_data;
          state_nx = LD_WR;
        end else if (in_valid) begin
          state_nx = last ? FINISH : LD_WAIT;
          offs_nx = offs + 13'(!last);
        end
      end
      LD_WR: begin
        if (mem_ack) begin
          state_nx = stop ? IDLE : last ? FINISH : LD_WAIT;
          aborted_nx = stop;
          offs_nx = offs + 13'(!last);
        end
      end
      SV_RD: begin
        // an abort seen during the read is held until the access has been acked
        if (mapped ? mem_ack : 1'b1) begin
          odata_nx = mapped ? mem_rdata : FILL_BYTE;
          state_nx = stop ? IDLE : SV_OUT;
          aborted_nx = stop;
        end
      end
      SV_OUT: begin
        if (abort) begin
          state_nx = IDLE;
          aborted_nx = 1'b1;
        end else if (out_ready) begin
          state_nx = last ? FINISH : SV_RD;
          offs_nx = offs + 13'(!last);
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      offs <= '0;
      abort_q <= 1'b0;
      aborted <= 1'b0;
      mem_wdata <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      offs <= offs_nx;
      abort_q <= abort_q_nx;
      aborted <= aborted_nx;
      mem_wdata <= wdata_nx;
      out_data <= odata_nx;
    end
  end
endmodule

// File: tb/tb_megacart_nvram_xfer.sv
// tb_megacart_nvram_xfer: random-stimulus bench with an SDRAM responder and a transaction-level image model
module tb_megacart_nvram_xfer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic load_req[2], save_req[2], abort[2], busy[2], cpu_hold[2], done[2], aborted[2];
  logic in_valid[2], in_ready[2], out_valid[2], out_ready[2];
  logic mem_req[2], mem_wr_n[2], mem_nvram_sel[2], mem_ack[2];
  logic [7:0] in_data[2], out_data[2], mem_wdata[2], mem_rdata[2];
  logic [15:0] mem_addr[2];
  logic [7:0] mem[2][65536];
  logic [7:0] out_log[2][8192];
  int n_cmp = 0, n_fail = 0;
  longint cyc = 0;
  int in_cnt[2], out_cnt[2], writes[2], reads[2], dones[2], aborts[2], ack_min[2], ack_max[2];
  longint ack_cyc[2], abort_cyc[2];
  logic pend[2], p_req[2], p_ack[2], p_ov[2], p_or[2], p_ab[2];
  logic [15:0] pa[2];
  logic [7:0] pd[2], p_od[2];
  logic [25:0] p_bus[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  megacart_nvram_xfer #(.COMPACT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load_req(load_req[0]), .save_req(save_req[0]), .abort(abort[0]),
    .busy(busy[0]), .cpu_hold(cpu_hold[0]), .done(done[0]), .aborted(aborted[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .mem_req(mem_req[0]), .mem_wr_n(mem_wr_n[0]), .mem_nvram_sel(mem_nvram_sel[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]));

  megacart_nvram_xfer #(.COMPACT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load_req(load_req[1]), .save_req(save_req[1]), .abort(abort[1]),
    .busy(busy[1]), .cpu_hold(cpu_hold[1]), .done(done[1]), .aborted(aborted[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .mem_req(mem_req[1]), .mem_wr_n(mem_wr_n[1]), .mem_nvram_sel(mem_nvram_sel[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // bit 16 = offset is mapped, bits 15:0 = CPU address
  function automatic logic [16:0] map_of(input bit compact, input int o);
    if (compact) return o < 3072 ? 17'h10000 | 17'(1024 + o) : 17'h10000 | 17'(38912 + o - 3072);
    if (o >= 1024 && o < 4096) return 17'h10000 | 17'(o);
    if (o >= 6144 && o < 8192) return 17'h10000 | 17'(32768 + o);
    return 17'h0;
  endfunction

  task automatic clr(input int i);
    in_cnt[i] = 0; out_cnt[i] = 0; writes[i] = 0; reads[i] = 0; dones[i] = 0; aborts[i] = 0;
    ack_cyc[i] = 0; abort_cyc[i] = 0; pend[i] = 0; pa[i] = 0; pd[i] = 0;
    p_req[i] = 0; p_ack[i] = 0; p_ov[i] = 0; p_or[i] = 0; p_ab[i] = 0; p_bus[i] = 0; p_od[i] = 0;
  endtask

  task automatic chk_reset(input int i);
    chk("rst_busy", 32'(busy[i]), 0);
    chk("rst_cpu_hold", 32'(cpu_hold[i]), 0);
    chk("rst_done", 32'(done[i]), 0);
    chk("rst_aborted", 32'(aborted[i]), 0);
    chk("rst_in_ready", 32'(in_ready[i]), 0);
    chk("rst_out_valid", 32'(out_valid[i]), 0);
    chk("rst_out_data", 32'(out_data[i]), 0);
    chk("rst_mem_req", 32'(mem_req[i]), 0);
    chk("rst_mem_wr_n", 32'(mem_wr_n[i]), 1);
    chk("rst_nvram_sel", 32'(mem_nvram_sel[i]), 0);
    chk("rst_mem_addr", 32'(mem_addr[i]), 0);
    chk("rst_mem_wdata", 32'(mem_wdata[i]), 0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    int cnt = 0, dly = 0;
    logic [16:0] m_in, m_out;
    always @(posedge clk) begin
      #1;
      if (!reset_n) begin
        mem_ack[g] = 1'b0;
        cnt = 0;
      end else if (mem_ack[g]) mem_ack[g] = 1'b0;
      else if (mem_req[g]) begin
        if (cnt == 0) dly = int'($urandom_range(ack_max[g], ack_min[g]));
        if (cnt >= dly) begin
          if (!mem_wr_n[g]) mem[g][mem_addr[g]] = mem_wdata[g];
          mem_rdata[g] = mem[g][mem_addr[g]];
          mem_ack[g] = 1'b1;
          cnt = 0;
        end else cnt++;
      end
    end
    always @(negedge clk) if (reset_n) begin
      chk("cpu_hold_eq_busy", 32'(cpu_hold[g]), 32'(busy[g]));
      chk("sel_eq_req", 32'(mem_nvram_sel[g]), 32'(mem_req[g]));
      if (p_req[g] && !p_ack[g])
        chk("mem_hold", 32'({mem_req[g], mem_wr_n[g], mem_addr[g], mem_wdata[g]}), 32'(p_bus[g]));
      if (p_ov[g] && !p_or[g] && !p_ab[g])
        chk("out_hold", 32'({out_valid[g], out_data[g]}), 32'({1'b1, p_od[g]}));
      if (in_valid[g] && in_ready[g]) begin
        m_in = map_of(g == 1, in_cnt[g]);
        if (m_in[16]) begin
          chk("wr_overrun", 32'(pend[g]), 0);
          pend[g] = 1'b1; pa[g] = m_in[15:0]; pd[g] = in_data[g];
        end
        in_cnt[g]++;
      end
      if (mem_req[g] && mem_ack[g]) begin
        if (!mem_wr_n[g]) begin
          chk("wr_expected", 32'(pend[g]), 1);
          chk("wr_addr_data", 32'({mem_addr[g], mem_wdata[g]}), 32'({pa[g], pd[g]}));
          pend[g] = 1'b0;
          writes[g]++;
        end else begin
          m_out = map_of(g == 1, out_cnt[g]);
          chk("rd_addr", 32'({1'b1, mem_addr[g]}), 32'(m_out));
          reads[g]++;
        end
        ack_cyc[g] = cyc;
      end
      if (out_valid[g] && out_ready[g]) begin
        m_out = map_of(g == 1, out_cnt[g]);
        chk("out_byte", 32'(out_data[g]), 32'(m_out[16] ? mem[g][m_out[15:0]] : 8'hFF));
        if (out_cnt[g] < 8192) out_log[g][out_cnt[g]] = out_data[g];
        out_cnt[g]++;
      end
      if (done[g]) dones[g]++;
      if (aborted[g]) begin
        aborts[g]++;
        abort_cyc[g] = cyc;
      end
      p_req[g] = mem_req[g]; p_ack[g] = mem_ack[g]; p_ov[g] = out_valid[g]; p_or[g] = out_ready[g];
      p_ab[g] = abort[g]; p_od[g] = out_data[g];
      p_bus[g] = {mem_req[g], mem_wr_n[g], mem_addr[g], mem_wdata[g]};
    end
  end

  task automatic run_load(input int i, input int prob, input int n);
    int k = 0, budget = 45000, d0 = dones[i];
    @(posedge clk); #1 load_req[i] = 1'b1;
    @(posedge clk); #1 load_req[i] = 1'b0;
    while (k < n && budget > 0) begin
      in_data[i] = 8'(k);
      in_valid[i] = int'($urandom_range(99)) < prob;
      @(negedge clk);
      if (in_valid[i] && in_ready[i]) k++;
      @(posedge clk); #1;
      budget--;
    end
    in_valid[i] = 1'b0;
    while (dones[i] == d0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1 chk("load_in_budget", 32'(budget > 0), 1);
  endtask

  task automatic run_save(input int i, input int prob, input int n, input int bp_at);
    int budget = 45000, d0 = dones[i], r0;
    logic [7:0] od;
    bit bp = 0;
    @(posedge clk); #1 save_req[i] = 1'b1;
    @(posedge clk); #1 save_req[i] = 1'b0;
    while (out_cnt[i] < n && budget > 0) begin
      if (!bp && out_cnt[i] == bp_at && out_valid[i]) begin
        out_ready[i] = 1'b0;
        r0 = reads[i];
        od = out_data[i];
        repeat (10) begin @(posedge clk); #1; end
        chk("bp_no_reads", 32'(reads[i]), 32'(r0));
        chk("bp_valid", 32'(out_valid[i]), 1);
        chk("bp_data", 32'(out_data[i]), 32'(od));
        bp = 1;
      end
      out_ready[i] = int'($urandom_range(99)) < prob;
      @(posedge clk); #1;
      budget--;
    end
    out_ready[i] = 1'b0;
    while (dones[i] == d0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1 chk("save_in_budget", 32'(budget > 0), 1);
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, w0, b0;
    for (int i = 0; i < 2; i++) begin
      load_req[i] = 0; save_req[i] = 0; abort[i] = 0; in_data[i] = 0; in_valid[i] = 0;
      out_ready[i] = 0; mem_rdata[i] = 0; mem_ack[i] = 0; ack_min[i] = 0; ack_max[i] = 1;
      clr(i);
    end
    for (int a = 0; a < 65536; a++) begin
      mem[0][a] = 8'h5A;
      mem[1][a] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);

    fork
      run_load(0, 75, 8192);
      run_save(1, 85, 5120, 2000);
    join
    chk("ld_writes", 32'(writes[0]), 5120);
    chk("ld_bytes", 32'(in_cnt[0]), 8192);
    chk("ld_done", 32'(dones[0]), 1);
    chk("ld_no_abort", 32'(aborts[0]), 0);
    chk("ld_0400", 32'(mem[0][16'h0400]), 32'h00);
    chk("ld_9fff", 32'(mem[0][16'h9FFF]), 32'hFF);
    bad = 0;
    for (int a = 0; a < 65536; a++) begin
      logic [7:0] e;
      e = ((a >= 16'h0400 && a < 16'h1000) || (a >= 16'h9800 && a < 16'hA000)) ? a[7:0] : 8'h5A;
      if (mem[0][a] !== e) bad++;
    end
    chk("ld_image", 32'(bad), 0);
    chk("cs_bytes", 32'(out_cnt[1]), 5120);
    chk("cs_reads", 32'(reads[1]), 5120);
    chk("cs_done", 32'(dones[1]), 1);
    chk("cs_first", 32'(out_log[1][0]), 32'(mem[1][16'h0400]));
    chk("cs_3071", 32'(out_log[1][3071]), 32'(mem[1][16'h0FFF]));
    chk("cs_3072", 32'(out_log[1][3072]), 32'(mem[1][16'h9800]));

    for (int a = 0; a < 65536; a++)
      if ((a >= 16'h0400 && a < 16'h1000) || (a >= 16'h9800 && a < 16'hA000)) mem[0][a] = 8'($urandom);
    clr(0);
    run_save(0, 85, 8192, 1500);
    chk("sv_bytes", 32'(out_cnt[0]), 8192);
    chk("sv_reads", 32'(reads[0]), 5120);
    chk("sv_done", 32'(dones[0]), 1);
    chk("sv_0000", 32'(out_log[0][0]), 32'hFF);
    chk("sv_1023", 32'(out_log[0][1023]), 32'hFF);
    chk("sv_4096", 32'(out_log[0][4096]), 32'hFF);
    chk("sv_6143", 32'(out_log[0][6143]), 32'hFF);
    chk("sv_1800", 32'(out_log[0][16'h1800]), 32'(mem[0][16'h9800]));
    chk("sv_8191", 32'(out_log[0][8191]), 32'(mem[0][16'h9FFF]));

    clr(1);
    ack_min[1] = 5; ack_max[1] = 5;
    @(posedge clk); #1 load_req[1] = 1'b1;
    @(posedge clk); #1 load_req[1] = 1'b0;
    in_data[1] = 8'hA5; in_valid[1] = 1'b1;
    @(posedge clk); #1 in_valid[1] = 1'b0;
    chk("abort_req_high", 32'(mem_req[1]), 1);
    abort[1] = 1'b1;
    @(posedge clk); #1 abort[1] = 1'b0;
    for (int t = 0; t < 30 && aborts[1] == 0; t++) @(posedge clk);
    #1;
    chk("abort_rq_aborted", 32'(aborts[1]), 1);
    chk("abort_rq_writes", 32'(writes[1]), 1);
    chk("abort_rq_no_done", 32'(dones[1]), 0);
    chk("abort_after_ack", 32'(abort_cyc[1] > ack_cyc[1]), 1);
    chk("abort_rq_mem", 32'(mem[1][16'h0400]), 32'hA5);
    chk("abort_rq_idle", 32'(busy[1]), 0);
    ack_min[1] = 0; ack_max[1] = 1;

    clr(0);
    @(posedge clk); #1 load_req[0] = 1'b1;
    @(posedge clk); #1 load_req[0] = 1'b0;
    @(posedge clk); #1 abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_wait_pulse", 32'(aborted[0]), 1);
    chk("abort_wait_idle", 32'(busy[0]), 0);
    @(posedge clk); #1;
    chk("abort_wait_count", 32'(aborts[0]), 1);
    chk("abort_wait_no_done", 32'(dones[0]), 0);
    @(negedge clk);
    chk("abort_wait_one_cycle", 32'(aborted[0]), 0);

    clr(1);
    @(posedge clk); #1 begin load_req[1] = 1'b1; save_req[1] = 1'b1; end
    @(posedge clk); #1 begin load_req[1] = 1'b0; save_req[1] = 1'b0; end
    chk("arb_load_ready", 32'(in_ready[1]), 1);
    chk("arb_no_save", 32'(out_valid[1]), 0);
    chk("arb_busy", 32'(busy[1]), 1);
    save_req[1] = 1'b1;
    @(posedge clk); #1 save_req[1] = 1'b0;
    in_data[1] = 8'h77; in_valid[1] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("arb_save_ignored", 32'(out_valid[1]), 0);
    end
    w0 = writes[1];
    b0 = in_cnt[1];
    chk("arb_loading", 32'(b0 > 0), 1);
    #3 reset_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    in_valid[1] = 1'b0;
    clr(0);
    clr(1);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(busy[1]), 0);
    chk("post_rst_no_done", 32'(dones[1]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
